// File: rtl/gcd_unit.sv
// Iterative subtractive GCD engine with valid/ready handshakes, abort and zero-operand handling.
// Optional subtraction counter output enabled by defining GCD_ITER_CNT_EN.
module gcd_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic             zero_err,
`ifdef GCD_ITER_CNT_EN
  output logic [WIDTH-1:0] iter_cnt,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             zerr_q, zerr_d;
`ifdef GCD_ITER_CNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      zerr_q  <= 1'b0;
`ifdef GCD_ITER_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      zerr_q  <= zerr_d;
`ifdef GCD_ITER_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    zerr_d  = zerr_q;
`ifdef GCD_ITER_CNT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = a_in;
          b_d = b_in;
`ifdef GCD_ITER_CNT_EN
          cnt_d = '0;
`endif
          if ((a_in != '0) && (b_in != '0)) begin
            state_d = CALC;
          end else begin
            // With at least one operand zero, OR yields the other operand (or 0).
            gcd_d   = a_in | b_in;
            zerr_d  = (a_in == '0) && (b_in == '0);
            state_d = DONE;
          end
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else if (a_q == b_q) begin
          gcd_d   = a_q;
          zerr_d  = 1'b0;
          state_d = DONE;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
`ifdef GCD_ITER_CNT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end else begin
          b_d = b_q - a_q;
`ifdef GCD_ITER_CNT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC);
  assign out_valid = (state_q == DONE);
  assign gcd_out   = gcd_q;
  assign zero_err  = zerr_q;
`ifdef GCD_ITER_CNT_EN
  assign iter_cnt  = cnt_q;
`endif

endmodule

// File: doc/gcd_unit.md
# gcd_unit

Parametrised iterative GCD engine using repeated subtraction, built as the successor to the fixed 16-bit GCD datapath/controller pair. Adds generic operand width, asynchronous reset, valid/ready handshakes on both sides, zero-operand handling, abort and an optional iteration counter. It sits between an operand producer and a result consumer, and computes one GCD at a time.

## Interface
- `WIDTH`, default 16: operand and result width in bits (legal range 2..32).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  producer presents `a_in`/`b_in`.
- `in_ready`  out  1  engine accepts operands; equals 1 exactly in IDLE.
- `a_in`  in  WIDTH  operand A, unsigned.
- `b_in`  in  WIDTH  operand B, unsigned.
- `abort`  in  1  synchronous; drops the current computation.
- `out_valid`  out  1  `gcd_out` is valid.
- `out_ready`  in  1  consumer takes the result.
- `gcd_out`  out  WIDTH  result, registered.
- `zero_err`  out  1  qualifies `gcd_out`; set when both operands were 0.
- `busy`  out  1  state is CALC.
- `iter_cnt`  out  WIDTH  number of subtractions performed; present only with `GCD_ITER_CNT_EN`.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - CALC: iterating; `busy`=1.
  - DONE: `out_valid`=1.
- Internal registers: A and B, WIDTH bits each, unsigned.
- Accept happens on an edge where `in_valid && in_ready`. On that edge A←`a_in` and B←`b_in`.
  - Both operands nonzero: next state CALC.
  - One operand 0: `gcd_out`←the other operand, `zero_err`←0, next state DONE.
  - Both operands 0: `gcd_out`←0, `zero_err`←1, next state DONE.
- CALC, evaluated each edge in this priority order:
  - `abort`: go to IDLE; `gcd_out` and `zero_err` are not updated.
  - A==B: `gcd_out`←A, `zero_err`←0, go to DONE.
  - A>B: A←A−B.
  - A<B: B←B−A.
- Each subtraction is a WIDTH-bit unsigned subtract. It cannot underflow, because the larger value is always the minuend.
- DONE: hold `out_valid`=1 and keep `gcd_out` stable until `out_ready`=1 on an edge, then go to IDLE.
  - `abort` has no effect in DONE.
  - `in_valid` is ignored in DONE because `in_ready`=0.
- `abort` in IDLE has no effect.
- `gcd_out` and `zero_err` hold their last values in IDLE and CALC; they change only on entry to DONE.

## Timing
- Reset (`rst_n`=0), asynchronously:
  - state IDLE, A=B=0;
  - `gcd_out`=0, `zero_err`=0, `iter_cnt`=0;
  - `out_valid`=0, `busy`=0;
  - `in_ready`=1.
- Reset asserted mid-CALC or mid-DONE: the computation is lost and no result is presented.
- Latency, counted from the accept edge to the first cycle with `out_valid`=1, where N is the number of subtractions:
  - nonzero operands: N+1 edges.
  - any zero operand: 1 edge.
- Worst case: operands (1, 2^WIDTH−1) give N=2^WIDTH−2.
- Throughput: the result handshake edge returns to IDLE. The earliest next accept is the following edge, so there is no overlap between computations.
- `in_ready`, `out_valid` and `busy` are decoded directly from the state register, with no combinational path from inputs.
- `abort` and `out_ready` in the same cycle cannot conflict, because they are meaningful in different states.

## Configuration
- `GCD_ITER_CNT_EN` defined:
  - `iter_cnt` port exists.
  - It clears to 0 on every accept and increments by 1 on each CALC subtraction edge.
  - It is frozen in DONE and IDLE.
  - It cannot overflow, since N ≤ 2^WIDTH−2.
- Not defined: the port and its counter logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=16, accept (48,18), `out_ready`=1 → `busy` for 5 cycles; `out_valid` 5 edges after accept; `gcd_out`=6, `zero_err`=0, `iter_cnt`=4; IDLE next cycle.
- Accept (7,7) → `out_valid` 1 edge after accept, `gcd_out`=7, `iter_cnt`=0. Accept (0,9) → `gcd_out`=9 after 1 edge. Accept (0,0) → `gcd_out`=0, `zero_err`=1.
- Accept (1,65535) → `out_valid` after 65535 edges, `gcd_out`=1, `iter_cnt`=65534.
- Accept (100,75); hold `out_ready`=0 for 10 cycles while toggling `in_valid` with new operands → `out_valid` and `gcd_out`=25 remain stable, no new accept; `out_ready`=1 → IDLE, `in_ready`=1.
- Accept (48,18); assert `abort` on the 2nd CALC edge → IDLE, `out_valid` never rises, `gcd_out` keeps its previous value; next accept (21,14) → `gcd_out`=7.
- Pulse `rst_n` low asynchronously mid-CALC → all outputs at reset values immediately; after release, accept (12,8) → `gcd_out`=4.
